// File: rtl/one_hot_scanner.sv
// ---------------------------------------------------------------------------
// one_hot_scanner
//   Time-multiplexed one-hot channel selector for digit / column selects.
//   A prescaler sets how long each channel is selected. The scan order is
//   up, down, ping-pong or hold. The registered binary index is presented
//   alongside the one-hot select.
//
// Optional feature (compile-time macro):
//   ONE_HOT_SCANNER_BLANKING_EN
//     When defined, every step or load forces all selects inactive for
//     BLANK_CYCLES cycles at the start of the new dwell, with o_blank high.
//     When undefined, o_blank is tied low and BLANK_CYCLES is unused.
//
// Parameters:
//   NUM_CHANNELS  number of select lines (2..256)
//   PRESCALE      clock cycles per channel dwell (>= 2)
//   ACTIVE_LOW    1 inverts o_one_hot so the active line is 0
//   BLANK_CYCLES  blanking length per switch (< PRESCALE)
//
// Ports:
//   i_clk         system clock, rising edge
//   i_reset_n     asynchronous active-low reset
//   i_enable      1 = prescaler runs; 0 = prescaler and index frozen
//   i_mode        00 up, 01 down, 10 ping-pong, 11 hold
//   i_load        synchronous load strobe (wins over a coincident step)
//   i_load_index  index to load; clamped to NUM_CHANNELS-1
//   o_one_hot     registered one-hot select
//   o_index       registered binary index of the selected channel
//   o_tick        one-cycle pulse on the first cycle of a stepped-to channel
//   o_blank       high while selects are forced inactive
// ---------------------------------------------------------------------------
module one_hot_scanner #(
  parameter int unsigned  NUM_CHANNELS = 4,
  parameter int unsigned  PRESCALE     = 1000,
  parameter bit           ACTIVE_LOW   = 1'b0,
  parameter int unsigned  BLANK_CYCLES = 16,
  localparam int unsigned IDX_W        = $clog2(NUM_CHANNELS)
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_enable,
  input  logic [1:0]              i_mode,
  input  logic                    i_load,
  input  logic [IDX_W-1:0]        i_load_index,
  output logic [NUM_CHANNELS-1:0] o_one_hot,
  output logic [IDX_W-1:0]        o_index,
  output logic                    o_tick,
  output logic                    o_blank
);

  localparam int unsigned CNT_W = $clog2(PRESCALE);

  localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(NUM_CHANNELS - 1);
  localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [NUM_CHANNELS-1:0] INACTIVE  = {NUM_CHANNELS{ACTIVE_LOW}};
  localparam logic [NUM_CHANNELS-1:0] RESET_SEL = INACTIVE ^ NUM_CHANNELS'(1);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PING = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  // Reject parameter sets the datapath cannot honour.
  if (NUM_CHANNELS < 2 || NUM_CHANNELS > 256 || PRESCALE < 2 ||
      BLANK_CYCLES >= PRESCALE) begin : g_bad_cfg
    $error("one_hot_scanner: illegal parameter combination");
  end

  // -------------------------------------------------------------------------
  // State and next-state signals
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [IDX_W-1:0]        r_index;
  logic [IDX_W-1:0]        w_index_nxt;
  logic                    r_dir;
  logic                    w_dir_nxt;
  logic                    r_tick;
  logic                    w_tick_nxt;
  logic [NUM_CHANNELS-1:0] r_one_hot;
  logic [NUM_CHANNELS-1:0] w_one_hot_nxt;
  logic                    w_blank_nxt;

  mode_e                   w_mode;
  logic                    w_wrap;
  logic                    w_step;
  logic                    w_ping_dir;
  logic [IDX_W:0]          w_ld_ext;
  logic [IDX_W-1:0]        w_ld_idx;
  logic [NUM_CHANNELS-1:0] w_sel;

  // Step qualification and load-index clamp.
  always_comb begin
    w_mode   = mode_e'(i_mode);
    w_wrap   = i_enable && (r_cnt == CNT_LAST);
    w_step   = w_wrap && (w_mode != MODE_HOLD);
    // One extra bit keeps the clamp compare meaningful for power-of-two N.
    w_ld_ext = {1'b0, i_load_index};
    w_ld_idx = (w_ld_ext > (IDX_W + 1)'(NUM_CHANNELS - 1)) ? LAST_IDX : i_load_index;
  end

  // Ping-pong direction with endpoint reversal applied before the move.
  always_comb begin
    w_ping_dir = r_dir;
    if (r_index == LAST_IDX) begin
      w_ping_dir = 1'b1;
    end else if (r_index == '0) begin
      w_ping_dir = 1'b0;
    end
  end

  // Next prescaler count, index, direction and tick.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_index_nxt = r_index;
    w_dir_nxt   = r_dir;
    w_tick_nxt  = 1'b0;

    if (i_load) begin
      w_cnt_nxt   = '0;
      w_index_nxt = w_ld_idx;
      w_dir_nxt   = (w_ld_idx == LAST_IDX);
    end else if (i_enable) begin
      w_cnt_nxt = w_wrap ? '0 : CNT_W'(r_cnt + 1'b1);
      if (w_step) begin
        w_tick_nxt = 1'b1;
        case (w_mode)
          MODE_UP: begin
            w_index_nxt = (r_index == LAST_IDX) ? '0 : IDX_W'(r_index + 1'b1);
          end
          MODE_DOWN: begin
            w_index_nxt = (r_index == '0) ? LAST_IDX : IDX_W'(r_index - 1'b1);
          end
          MODE_PING: begin
            w_dir_nxt   = w_ping_dir;
            w_index_nxt = w_ping_dir ? IDX_W'(r_index - 1'b1) : IDX_W'(r_index + 1'b1);
          end
          default: begin
            w_index_nxt = r_index;
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Optional blanking: counts remaining blank cycles of the current dwell.
  // -------------------------------------------------------------------------
`ifdef ONE_HOT_SCANNER_BLANKING_EN
  localparam int unsigned BLK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  logic [BLK_W-1:0] r_blank_cnt;
  logic [BLK_W-1:0] w_blank_cnt_nxt;
  logic             r_blank;

  // Restart on every step or load; count down only while enabled.
  always_comb begin
    w_blank_cnt_nxt = r_blank_cnt;
    if (i_load || w_step) begin
      w_blank_cnt_nxt = BLK_W'(BLANK_CYCLES);
    end else if (i_enable && (r_blank_cnt != '0)) begin
      w_blank_cnt_nxt = BLK_W'(r_blank_cnt - 1'b1);
    end
    w_blank_nxt = (w_blank_cnt_nxt != '0);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_blank_cnt <= '0;
      r_blank     <= 1'b0;
    end else begin
      r_blank_cnt <= w_blank_cnt_nxt;
      r_blank     <= w_blank_nxt;
    end
  end

  assign o_blank = r_blank;
`else
  assign w_blank_nxt = 1'b0;
  assign o_blank     = 1'b0;
`endif

  // Decode the next index so the select registers align with o_index.
  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (w_index_nxt == IDX_W'(i)) begin
        w_sel[i] = 1'b1;
      end
    end
    w_one_hot_nxt = (w_blank_nxt ? '0 : w_sel) ^ INACTIVE;
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt     <= '0;
      r_index   <= '0;
      r_dir     <= 1'b0;
      r_tick    <= 1'b0;
      r_one_hot <= RESET_SEL;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_index   <= w_index_nxt;
      r_dir     <= w_dir_nxt;
      r_tick    <= w_tick_nxt;
      r_one_hot <= w_one_hot_nxt;
    end
  end

  assign o_one_hot = r_one_hot;
  assign o_index   = r_index;
  assign o_tick    = r_tick;

endmodule

// File: tb/tb_one_hot_scanner.sv
// ---------------------------------------------------------------------------
// tb_one_hot_scanner
//   Two scanner instances share one stimulus stream:
//     A: 4 channels, dwell 4, active-high
//     B: 5 channels, dwell 8, active-low
//   A behavioural model follows each instance and is compared on every
//   falling edge. Directed sections pin the model with literal expectations,
//   and a random section exercises mode, enable and load mixes.
// ---------------------------------------------------------------------------
module tb_one_hot_scanner;

  localparam int NA = 4, PA = 4, BA = 2;
  localparam int NB = 5, PB = 8, BB = 2;
`ifdef ONE_HOT_SCANNER_BLANKING_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b0;
  logic [1:0] mode  = 2'b00;
  logic       ld    = 1'b0;
  logic [1:0] li_a  = '0;
  logic [2:0] li_b  = '0;

  logic [NA-1:0] oh_a;
  logic [1:0]    idx_a;
  logic          tick_a, blank_a;
  logic [NB-1:0] oh_b;
  logic [2:0]    idx_b;
  logic          tick_b, blank_b;

  always #5 clk = ~clk;

  one_hot_scanner #(.NUM_CHANNELS(NA), .PRESCALE(PA), .ACTIVE_LOW(1'b0), .BLANK_CYCLES(BA)) u_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_mode(mode), .i_load(ld),
    .i_load_index(li_a), .o_one_hot(oh_a), .o_index(idx_a), .o_tick(tick_a), .o_blank(blank_a));

  one_hot_scanner #(.NUM_CHANNELS(NB), .PRESCALE(PB), .ACTIVE_LOW(1'b1), .BLANK_CYCLES(BB)) u_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_mode(mode), .i_load(ld),
    .i_load_index(li_b), .o_one_hot(oh_b), .o_index(idx_b), .o_tick(tick_b), .o_blank(blank_b));

  int n_tests = 0;
  int n_fail  = 0;
  bit blank_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    int cnt;   // cycles already spent in this dwell
    int idx;
    int dir;
    int blk;   // blank cycles still to show
    bit tick;
  } ms_t;

  function automatic ms_t ms_zero();
    ms_t z;
    z.cnt = 0; z.idx = 0; z.dir = 0; z.blk = 0; z.tick = 1'b0;
    return z;
  endfunction

  function automatic ms_t mnext(input ms_t s, input int n, input int p, input int b,
                                input bit en_i, input int md, input bit ld_i, input int lidx);
    ms_t r;
    r = s;
    r.tick = 1'b0;
    if (ld_i) begin
      r.idx = (lidx > n - 1) ? n - 1 : lidx;
      r.cnt = 0;
      r.dir = (r.idx == n - 1) ? 1 : 0;
      r.blk = BLANK_ON ? b : 0;
    end else if (en_i) begin
      if (r.blk > 0) r.blk = r.blk - 1;
      if (s.cnt == p - 1) begin
        r.cnt = 0;
        if (md != 3) begin
          r.tick = 1'b1;
          r.blk  = BLANK_ON ? b : 0;
          case (md)
            0: r.idx = (s.idx + 1) % n;
            1: r.idx = (s.idx + n - 1) % n;
            default: begin
              if (s.idx == n - 1) r.dir = 1;
              else if (s.idx == 0) r.dir = 0;
              r.idx = (r.dir != 0) ? s.idx - 1 : s.idx + 1;
            end
          endcase
        end
      end else begin
        r.cnt = s.cnt + 1;
      end
    end
    return r;
  endfunction

  function automatic int exp_oh(input ms_t s, input int n, input bit al);
    int v;
    v = (s.blk != 0) ? 0 : (1 << s.idx);
    if (al) v = ~v & ((1 << n) - 1);
    return v;
  endfunction

  ms_t m_a = '0;
  ms_t m_b = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= ms_zero();
      m_b <= ms_zero();
    end else begin
      m_a <= mnext(m_a, NA, PA, BA, en, int'(mode), ld, int'(li_a));
      m_b <= mnext(m_b, NB, PB, BB, en, int'(mode), ld, int'(li_b));
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("a_one_hot", 32'(oh_a),    32'(exp_oh(m_a, NA, 1'b0)));
    check("a_index",   32'(idx_a),   32'(m_a.idx));
    check("a_tick",    32'(tick_a),  32'(m_a.tick));
    check("a_blank",   32'(blank_a), (m_a.blk != 0) ? 32'd1 : 32'd0);
    check("b_one_hot", 32'(oh_b),    32'(exp_oh(m_b, NB, 1'b1)));
    check("b_index",   32'(idx_b),   32'(m_b.idx));
    check("b_tick",    32'(tick_b),  32'(m_b.tick));
    check("b_blank",   32'(blank_b), (m_b.blk != 0) ? 32'd1 : 32'd0);
    if (blank_a || blank_b) blank_seen = 1'b1;
  end

  // ---------------- directed + random stimulus ----------------
  int exp_down[5] = '{4, 3, 2, 1, 0};
  int exp_ping[9] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};

  task automatic wait_tick_b(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 4 * PB; c++) begin
      @(negedge clk);
      if (tick_b) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_tick_a(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 4 * PA; c++) begin
      @(negedge clk);
      if (tick_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_both(input logic [1:0] a, input logic [2:0] b);
    @(negedge clk);
    ld = 1'b1; li_a = a; li_b = b;
    @(negedge clk);
    ld = 1'b0;
  endtask

  initial begin
    bit ok;
    int e;

    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_oh_a",  32'(oh_a),   32'h1);
    check("rst_idx_a", 32'(idx_a),  32'h0);
    check("rst_tick_a", 32'(tick_a), 32'h0);
    check("rst_oh_b",  32'(oh_b),   32'h1E);
    check("rst_blank_b", 32'(blank_b), 32'h0);

    // Basic up scan on A: 4 cycles per channel.
    rst_n = 1'b1; en = 1'b1; mode = 2'b00;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      e = (BLANK_ON && k >= 4 && (k % 4) < 2) ? 0 : (1 << ((k / 4) % 4));
      check("scan_oh_a",   32'(oh_a),   32'(e));
      check("scan_tick_a", 32'(tick_a), (k % 4 == 0) ? 32'd1 : 32'd0);
    end

    // Down scan on B (N=5).
    mode = 2'b01;
    load_both(2'd0, 3'd0);
    for (int k = 0; k < 5; k++) begin
      wait_tick_b(ok);
      check("down_tick_seen", 32'(ok), 32'd1);
      check("down_idx_b", 32'(idx_b), 32'(exp_down[k]));
    end

    // Ping-pong on B: endpoints not repeated.
    mode = 2'b10;
    load_both(2'd0, 3'd0);
    for (int k = 0; k < 9; k++) begin
      wait_tick_b(ok);
      check("ping_tick_seen", 32'(ok), 32'd1);
      check("ping_idx_b", 32'(idx_b), 32'(exp_ping[k]));
    end

    // Load clamp and active-low patterns on B.
    load_both(2'd3, 3'd7);
    check("clamp_idx_b",  32'(idx_b),  32'd4);
    check("clamp_tick_b", 32'(tick_b), 32'd0);
    check("clamp_oh_b",   32'(oh_b),   BLANK_ON ? 32'h1F : 32'h0F);
    check("load_idx_a",   32'(idx_a),  32'd3);
    load_both(2'd1, 3'd3);
    check("al_oh_b",      32'(oh_b),   BLANK_ON ? 32'h1F : 32'h17);

    // Load coincident with a step on A.
    mode = 2'b00;
    wait_tick_a(ok);
    check("coinc_tick_seen", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    ld = 1'b1; li_a = 2'd2;
    @(negedge clk);
    ld = 1'b0;
    check("coinc_idx_a",  32'(idx_a),  32'd2);
    check("coinc_tick_a", 32'(tick_a), 32'd0);
    for (int k = 5; k <= 8; k++) begin
      @(negedge clk);
      check("coinc_next_tick", 32'(tick_a), (k == 8) ? 32'd1 : 32'd0);
    end
    check("coinc_next_idx", 32'(idx_a), 32'd3);

    // Enable low mid-dwell on A: freeze, then resume where it stopped.
    load_both(2'd1, 3'd0);
    repeat (2) @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("frz_idx_a",  32'(idx_a),  32'd1);
      check("frz_tick_a", 32'(tick_a), 32'd0);
    end
    en = 1'b1;
    @(negedge clk);
    check("resume_tick0", 32'(tick_a), 32'd0);
    @(negedge clk);
    check("resume_tick1", 32'(tick_a), 32'd1);
    check("resume_idx",   32'(idx_a),  32'd2);

    // Hold mode: prescaler runs, index fixed, no tick.
    mode = 2'b11;
    load_both(2'd2, 3'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("hold_idx_a", 32'(idx_a), 32'd2);
      check("hold_idx_b", 32'(idx_b), 32'd1);
      check("hold_tick",  32'(tick_a | tick_b), 32'd0);
    end

    // Blank window after a load then after the following step on B.
    mode = 2'b00;
    load_both(2'd0, 3'd0);
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      if (BLANK_ON) e = (k <= 2 || k >= 9) ? 32'h1F : 32'h1E;
      else          e = (k <= 8) ? 32'h1E : 32'h1D;
      check("blank_win_oh_b", 32'(oh_b), 32'(e));
      check("blank_win_b", 32'(blank_b), (BLANK_ON && (k <= 2 || k >= 9)) ? 32'd1 : 32'd0);
    end

    // Randomised mix of modes, enable gaps and loads.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
      ld   = ($urandom_range(0, 15) == 0);
      li_a = 2'($urandom_range(0, 3));
      li_b = 3'($urandom_range(0, 7));
    end

    // Asynchronous reset mid-dwell.
    mode = 2'b00; en = 1'b1;
    load_both(2'd3, 3'd3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_oh_a",  32'(oh_a),  32'h1);
    check("async_idx_a", 32'(idx_a), 32'h0);
    check("async_oh_b",  32'(oh_b),  32'h1E);
    check("async_idx_b", 32'(idx_b), 32'h0);
    check("async_blank", 32'(blank_a | blank_b), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    check("blank_seen", 32'(blank_seen), 32'(BLANK_ON));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
